// File: rtl/div_pkg.sv
// div_pkg: shared types for the divider request front-end.
// Holds the sequencer state encoding and the watchdog limit.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } div_state_e;

    // Number of WAIT cycles allowed before the divider is declared hung.
    function automatic int DIV_TIMEOUT(input int n);
        return 2 * n + 2;
    endfunction

endpackage

// File: rtl/div_seq_wdog.sv
// div_seq_wdog: WAIT-state watchdog for div_seq.
// Cleared on operand load, counts WAIT cycles, flags the last allowed one.
module div_seq_wdog
    import div_pkg::*;
#(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int TMO = DIV_TIMEOUT(N);
    localparam int W   = $clog2(2 * N + 3);
    localparam logic [W-1:0] CNT_MAX  = W'(TMO);
    localparam logic [W-1:0] CNT_LAST = W'(TMO - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear on load, otherwise count enabled cycles and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The edge ending this cycle would bring the count to the limit.
    assign expired_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/div_seq.sv
// div_seq: handshake front-end sequencing the shift-subtract divider.
// Optional remainder datapath is compiled in with DIV_SEQ_REM_EN.
module div_seq
    import div_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_dividend,
    input  logic [N-1:0] in_divisor,
    output logic         sen1,
    output logic         sen2,
    output logic [N-1:0] div_dividend,
    output logic [N-1:0] div_divisor,
    input  logic [N-1:0] div_q,
    input  logic         div_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_q,
`ifdef DIV_SEQ_REM_EN
    output logic [N-1:0] out_rem,
`endif
    output logic         out_dz,
    output logic         out_err
);

    div_state_e state_q;
    div_state_e state_d;

    logic [N-1:0] dvd_q, dvd_d;
    logic [N-1:0] dvs_q, dvs_d;
    logic [N-1:0] q_q,   q_d;
    logic         dz_q,  dz_d;
    logic         err_q, err_d;
`ifdef DIV_SEQ_REM_EN
    logic [N-1:0]   rem_q, rem_d;
    logic [2*N-1:0] prod;
`endif

    logic wd_clr;
    logic wd_en;
    logic wd_exp;
    logic div_zero;

    assign div_zero = (in_divisor == '0);

    div_seq_wdog #(
        .N(N)
    ) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_exp)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; div_done is only trusted in WAIT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = div_zero ? RESP : START;
                end
            end
            START: state_d = LOAD;
            LOAD:  state_d = WAIT;
            WAIT: begin
                if (div_done || wd_exp) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State-decoded handshake and divider strobes.
    always_comb begin
        in_ready  = (state_q == IDLE);
        sen1      = (state_q == START);
        sen2      = (state_q == LOAD);
        out_valid = (state_q == RESP);
        wd_clr    = (state_q == LOAD);
        wd_en     = (state_q == WAIT);
    end

`ifdef DIV_SEQ_REM_EN
    // Quotient times divisor, full width; low half is all that matters.
    assign prod = (2*N)'(div_q) * (2*N)'(dvs_q);
`endif

    // Operand capture and result capture.
    always_comb begin
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        q_d   = q_q;
        dz_d  = dz_q;
        err_d = err_q;
`ifdef DIV_SEQ_REM_EN
        rem_d = rem_q;
`endif
        if ((state_q == IDLE) && in_valid) begin
            dvd_d = in_dividend;
            dvs_d = in_divisor;
            if (div_zero) begin
                q_d   = '1;
                dz_d  = 1'b1;
                err_d = 1'b0;
`ifdef DIV_SEQ_REM_EN
                rem_d = in_dividend;
`endif
            end
        end else if (state_q == WAIT) begin
            if (div_done) begin
                q_d   = div_q;
                dz_d  = 1'b0;
                err_d = 1'b0;
`ifdef DIV_SEQ_REM_EN
                rem_d = dvd_q - prod[N-1:0];
`endif
            end else if (wd_exp) begin
                q_d   = '0;
                dz_d  = 1'b0;
                err_d = 1'b1;
`ifdef DIV_SEQ_REM_EN
                rem_d = '0;
`endif
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_q <= '0;
            dvs_q <= '0;
            q_q   <= '0;
            dz_q  <= 1'b0;
            err_q <= 1'b0;
`ifdef DIV_SEQ_REM_EN
            rem_q <= '0;
`endif
        end else begin
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            q_q   <= q_d;
            dz_q  <= dz_d;
            err_q <= err_d;
`ifdef DIV_SEQ_REM_EN
            rem_q <= rem_d;
`endif
        end
    end

    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign out_q        = q_q;
    assign out_dz       = dz_q;
    assign out_err      = err_q;
`ifdef DIV_SEQ_REM_EN
    assign out_rem      = rem_q;
`endif

endmodule

// File: doc/div_seq.md
# div_seq

Request front-end for the shift-subtract divider (`div`, instantiated alongside it in the parent).
- Upstream side: accepts one operand pair per transaction over a valid/ready handshake.
- Divider side: sequences the divider's `sen1`/`sen2` start protocol and holds operands stable.
- Watches `done`, captures the quotient, optionally computes the remainder, and presents the result on a valid/ready output.
- Handles divide-by-zero locally and flags a hung divider.

## Interface
- `N`, default 4: operand/quotient width. Must match the divider's `N`; N ≥ 2.
- `clk`  in  1  rising-edge clock; shared with the divider.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept a pair.
- `in_dividend`  in  N  dividend.
- `in_divisor`  in  N  divisor.
- `sen1`  out  1  divider start, step 1.
- `sen2`  out  1  divider start, step 2 (operand load).
- `div_dividend`  out  N  registered dividend driven to the divider.
- `div_divisor`  out  N  registered divisor driven to the divider.
- `div_q`  in  N  divider quotient.
- `div_done`  in  1  divider done level.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_q`  out  N  quotient.
- `out_rem`  out  N  remainder; present only with `DIV_SEQ_REM_EN`.
- `out_dz`  out  1  divide-by-zero flag.
- `out_err`  out  1  watchdog timeout flag.

## Operation
- States: IDLE, START, LOAD, WAIT, RESP.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, capture both operands into `div_dividend`/`div_divisor`.
  - Divisor==0 → RESP with `out_q`={N{1}}, `out_rem`=dividend, `out_dz`=1. The divider is never started.
  - Otherwise → START.
- START: `sen1`=1 for exactly one cycle → LOAD.
- LOAD: `sen2`=1 for exactly one cycle. The divider loads operands and clears `done` at this edge. Clear the watchdog counter → WAIT.
- WAIT:
  - Increment the watchdog counter each cycle.
  - `div_done`=1 → capture `div_q` into `out_q` (and the remainder) → RESP with `out_dz`=0, `out_err`=0.
  - If the counter reaches 2N+2 without `div_done` → RESP with `out_q`=0, `out_rem`=0, `out_err`=1.
- RESP:
  - `out_valid`=1; all outputs held stable.
  - `out_valid & out_ready` → IDLE.
- Remainder: `out_rem` = dividend − (`div_q` × divisor). The product is computed 2N wide and truncated to N bits; the result never underflows for legal operands.
- `sen1`/`sen2` are never asserted outside START/LOAD; both are 0 in every other state.
- `in_ready` is 0 in every state except IDLE. No queueing: at most one transaction is in flight.

## Timing
- Reset values: state IDLE; `in_ready`=1 after reset release; `sen1`=`sen2`=0; `div_dividend`=`div_divisor`=0; `out_valid`=0; `out_q`=`out_rem`=0; `out_dz`=`out_err`=0.
- Normal latency, from the IDLE accept edge to the first `out_valid` cycle: 2N+3 cycles (START 1, LOAD 1, WAIT 2N, capture edge 1). For N=4 this is 11.
- Divide-by-zero latency: 1 cycle from the accept edge to `out_valid`.
- `div_done` is a level that may still be high from the previous transaction. It is ignored in all states except WAIT, and the divider has cleared it before WAIT is entered.
- Back-to-back: with `out_ready` held 1, RESP lasts 1 cycle, then IDLE for 1 cycle accepts the next pair. Sustained throughput is 1 result per 2N+4 cycles.
- Reset mid-transaction returns to IDLE on the next edge and discards the in-flight result. The parent must reset the divider in the same cycle by driving `reset_n` = ~`reset`.
- After a timeout: the block returns to IDLE normally. Recovering the divider is the parent's responsibility.

## Configuration
- `DIV_SEQ_REM_EN` defined: the remainder datapath, the `out_rem` port and its registers are compiled in.
- `DIV_SEQ_REM_EN` undefined: the port, the multiplier and the subtractor are all absent. Quotient, flags and timing are unchanged.

## Structure
- Shared package `div_pkg` holds:
  - the state enum (IDLE/START/LOAD/WAIT/RESP);
  - the localparam `DIV_TIMEOUT(N)` = 2N+2.
- One sub-module is natural: `div_seq_wdog`, the watchdog counter with clear/enable inputs and an `expired` output, width $clog2(2N+3).

## Test plan
- N=4, 13/3, `out_ready`=1:
  - `sen1` is high 1 cycle after accept, then `sen2` high the next cycle.
  - `out_valid` goes high 11 cycles after accept with `out_q`=4, `out_rem`=1, `out_dz`=0.
- 9/0 → `out_valid` 1 cycle after accept, `out_q`=15, `out_rem`=9, `out_dz`=1; `sen1` never asserted.
- Back-to-back 15/1 then 0/7, with `out_ready` low for 3 cycles on the first result:
  - `out_q`=15 is held stable and `in_ready` stays 0 while stalled.
  - The second result is `out_q`=0, `out_rem`=0.
- Divider stub that never raises `done` → `out_err`=1, `out_q`=0 after 2N+2 WAIT cycles; the next transaction then completes normally.
- Stale `done`: leave `div_done` high from the previous op and issue 8/2 → result waits the full latency and gives `out_q`=4; it must not complete early.
- Assert `reset` during WAIT → next cycle IDLE with all outputs at their reset values; a following 7/2 gives `out_q`=3, `out_rem`=1.
